// File: rtl/partial_lane_pkg.sv
// Shared types and default constants for the partial lane mux slice.
package partial_lane_pkg;

  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_LANE_W    = 16;
  localparam int DEF_STAT_W    = 4;

  // Output sequencer states: IDLE has nothing held, FULL presents the whole
  // word in one beat, SPLIT_HI/SPLIT_LO present the upper then lower half.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FULL     = 2'd1,
    SPLIT_HI = 2'd2,
    SPLIT_LO = 2'd3
  } lane_state_e;

  // Width of a lane index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/partial_lane_rr_arb.sv
// Combinational round-robin arbiter: searches for the first eligible lane
// strictly after the last-granted pointer, wrapping from the top lane to 0.
module partial_lane_rr_arb
  import partial_lane_pkg::*;
#(
  parameter  int NUM_LANES = DEF_NUM_LANES,
  localparam int IDX_W     = idx_width(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_grant
);

  int idx;

  // Walk lanes ptr+1, ptr+2, ... ptr (wrapped) and take the first hit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value held (no latch).
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = (int'(ptr) + i) % NUM_LANES;
      if (!any_grant && eligible[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/partial_lane_mux.sv
// Round-robin lane multiplexer that forwards one lane word at a time, either
// as a single full beat or as two half beats (upper half first).
// Optional feature: define PARTIAL_LANE_MUX_STATS_EN to add per-lane
// saturating counters of accepted words on port stat_count.
module partial_lane_mux
  import partial_lane_pkg::*;
#(
  parameter  int NUM_LANES = DEF_NUM_LANES,
  parameter  int LANE_W    = DEF_LANE_W,
  parameter  int STAT_W    = DEF_STAT_W,
  localparam int HW        = LANE_W / 2,
  localparam int IDX_W     = idx_width(NUM_LANES)
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset_n,
  input  logic [NUM_LANES-1:0]          lane_en,
  input  logic [NUM_LANES-1:0]          in_valid,
  output logic [NUM_LANES-1:0]          in_ready,
  input  logic [NUM_LANES*LANE_W-1:0]   in_data,
  input  logic [NUM_LANES*STAT_W-1:0]   in_status,
  input  logic                          split_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HW-1:0]                 out_hi,
  output logic [HW-1:0]                 out_lo,
  output logic                          out_last,
  output logic [IDX_W-1:0]              out_lane,
  output logic [NUM_LANES*2-1:0]        status_low,
`ifdef PARTIAL_LANE_MUX_STATS_EN
  output logic [NUM_LANES*16-1:0]       stat_count,
`endif
  output logic                          system_ready
);

  lane_state_e            state_q, state_d;
  logic [LANE_W-1:0]      word_q;
  logic [IDX_W-1:0]       lane_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [NUM_LANES*2-1:0] status_q;

  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_grant;
  logic                   window;
  logic                   accept;

  assign eligible = in_valid & lane_en;

  partial_lane_rr_arb #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A new word may be taken while idle, or in the very cycle the final beat
  // of the current word leaves, which keeps back-to-back words bubble-free.
  assign window   = (state_q == IDLE) || (out_valid && out_ready && out_last);
  assign accept   = window && any_grant;
  assign in_ready = window ? grant : '0;

  // Next-state selection: acceptance chooses the beat format, otherwise only
  // the upper split beat advances on a handshake; everything else holds.
  always_comb begin
    state_d = state_q;
    if (window) begin
      if (any_grant) begin
        state_d = split_mode ? SPLIT_HI : FULL;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == SPLIT_HI && out_ready) begin
      state_d = SPLIT_LO;
    end
  end

  // Control state, source lane, arbitration pointer and captured status.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q  <= IDLE;
      lane_q   <= '0;
      ptr_q    <= IDX_W'(NUM_LANES - 1);
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lane_q <= grant_idx;
        ptr_q  <= grant_idx;
        status_q[int'(grant_idx)*2 +: 2] <= in_status[int'(grant_idx)*STAT_W +: 2];
      end
    end
  end

  // Captured word. Its contents are never visible outside FULL/SPLIT states,
  // so it needs no reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: pure datapath storage is left unreset; the state register gates
    // every use of it, which keeps reset fan-out on control bits only.
    if (accept) begin
      word_q <= in_data[int'(grant_idx)*LANE_W +: LANE_W];
    end
  end

  // Output beat formatting driven straight from the state register, so a
  // reset assertion clears the outputs without waiting for a clock edge.
  always_comb begin
    out_valid = 1'b0;
    out_hi    = '0;
    out_lo    = '0;
    out_last  = 1'b0;
    unique case (state_q)
      FULL: begin
        out_valid = 1'b1;
        out_hi    = word_q[LANE_W-1:HW];
        out_lo    = word_q[HW-1:0];
        out_last  = 1'b1;
      end
      SPLIT_HI: begin
        out_valid = 1'b1;
        out_lo    = word_q[LANE_W-1:HW];
      end
      SPLIT_LO: begin
        out_valid = 1'b1;
        out_lo    = word_q[HW-1:0];
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_lane     = lane_q;
  assign status_low   = status_q;
  assign system_ready = (state_q == IDLE);

`ifdef PARTIAL_LANE_MUX_STATS_EN
  // Per-lane accepted-word counters, saturating at all ones.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_stat
    logic [15:0] count_q;

    // Count each acceptance of this lane until the counter saturates.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
        count_q <= '0;
      end else if (accept && grant[k] && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'd1;
      end
    end

    assign stat_count[k*16 +: 16] = count_q;
  end
`endif

endmodule

// File: tb/tb_partial_lane_mux.sv
// Directed, table-driven bench for partial_lane_mux (default parameters).
module tb_partial_lane_mux;

  logic        sys_clk;
  logic        sys_reset_n;
  logic [1:0]  lane_en;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_status;
  logic        split_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_hi;
  logic [7:0]  out_lo;
  logic        out_last;
  logic        out_lane;
  logic [3:0]  status_low;
  logic        system_ready;
`ifdef PARTIAL_LANE_MUX_STATS_EN
  logic [31:0] stat_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  partial_lane_mux dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .lane_en      (lane_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_status    (in_status),
    .split_mode   (split_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .out_last     (out_last),
    .out_lane     (out_lane),
    .status_low   (status_low),
`ifdef PARTIAL_LANE_MUX_STATS_EN
    .stat_count   (stat_count),
`endif
    .system_ready (system_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        split;
    logic        ordy;
    logic [1:0]  rdy;
    logic        vld;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        last;
    logic        lane;
    logic [3:0]  stl;
    logic        srdy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] rdy, input logic vld,
                           input logic [7:0] hi, input logic [7:0] lo, input logic last,
                           input logic lane);
    check({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    check({tag, ".out_hi"},    32'(out_hi),    32'(hi));
    check({tag, ".out_lo"},    32'(out_lo),    32'(lo));
    check({tag, ".out_last"},  32'(out_last),  32'(last));
    check({tag, ".out_lane"},  32'(out_lane),  32'(lane));
  endtask

  task automatic drive(input logic [1:0] en, input logic [1:0] valid, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [3:0] s0, input logic [3:0] s1,
                       input logic split, input logic ordy);
    lane_en    = en;
    in_valid   = valid;
    in_data    = {d1, d0};
    in_status  = {s1, s0};
    split_mode = split;
    out_ready  = ordy;
  endtask

  initial begin
    // Each row is one cycle: inputs driven at the falling edge, outputs
    // checked just after, and the following rising edge consumes the row.
    vecs[0]  = '{2'b11, 2'b01, 16'hA55A, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[1]  = '{2'b11, 2'b00, 16'h0000, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 16'h1111, 16'h2222, 4'h1, 4'h3, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 16'h3333, 16'h4444, 4'h1, 4'h3, 1'b0, 1'b1, 2'b01, 1'b1, 8'h22, 8'h22, 1'b1, 1'b1, 4'b1110, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 16'h5555, 16'h6666, 4'h1, 4'h2, 1'b0, 1'b1, 2'b10, 1'b1, 8'h33, 8'h33, 1'b1, 1'b0, 4'b1101, 1'b0};
    vecs[5]  = '{2'b11, 2'b00, 16'h0000, 16'h0000, 4'h1, 4'h2, 1'b0, 1'b1, 2'b00, 1'b1, 8'h66, 8'h66, 1'b1, 1'b1, 4'b1001, 1'b0};
    vecs[6]  = '{2'b01, 2'b10, 16'h0000, 16'h7777, 4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'b1001, 1'b1};
    vecs[7]  = '{2'b01, 2'b11, 16'h8888, 16'h7777, 4'h0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'b1001, 1'b1};
    vecs[8]  = '{2'b01, 2'b11, 16'h9999, 16'h7777, 4'h0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h88, 8'h88, 1'b1, 1'b0, 4'b1000, 1'b0};
    vecs[9]  = '{2'b01, 2'b10, 16'h0000, 16'h7777, 4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h99, 8'h99, 1'b1, 1'b0, 4'b1000, 1'b0};
    vecs[10] = '{2'b11, 2'b01, 16'h1234, 16'h0000, 4'h3, 4'h0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b1000, 1'b1};
    vecs[11] = '{2'b11, 2'b01, 16'hABCD, 16'h0000, 4'h3, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 8'h12, 1'b0, 1'b0, 4'b1011, 1'b0};
    vecs[12] = '{2'b11, 2'b01, 16'hABCD, 16'h0000, 4'h3, 4'h0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h00, 8'h34, 1'b1, 1'b0, 4'b1011, 1'b0};
    vecs[13] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 4'h3, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 8'hAB, 8'hCD, 1'b1, 1'b0, 4'b1011, 1'b0};
    vecs[14] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 4'h3, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 8'hAB, 8'hCD, 1'b1, 1'b0, 4'b1011, 1'b0};
    vecs[15] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 4'h3, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b1011, 1'b1};

    // Reset state.
    sys_reset_n = 1'b0;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    check_out("reset", 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset.status_low",   32'(status_low),   32'h0);
    check("reset.system_ready", 32'(system_ready), 32'h1);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;

    // Table-driven main sequence.
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      drive(vecs[i].en, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].s0, vecs[i].s1,
            vecs[i].split, vecs[i].ordy);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].vld, vecs[i].hi, vecs[i].lo,
                vecs[i].last, vecs[i].lane);
      check($sformatf("vec%0d.status_low", i),   32'(status_low),   32'(vecs[i].stl));
      check($sformatf("vec%0d.system_ready", i), 32'(system_ready), 32'(vecs[i].srdy));
    end

    // Stall in SPLIT_HI for five cycles while split_mode and lane_en change.
    @(negedge sys_clk);
    drive(2'b11, 2'b10, 16'h0000, 16'hBEEF, 4'h0, 4'h0, 1'b1, 1'b0);
    #1;
    check("stall.grant_lane1", 32'(in_ready), 32'h2);
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      drive(2'b00, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, c[0], 1'b0);
      #1;
      check_out($sformatf("stall%0d", c), 2'b00, 1'b1, 8'h00, 8'hBE, 1'b0, 1'b1);
    end
    @(negedge sys_clk);
    drive(2'b11, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check_out("stall_release", 2'b00, 1'b1, 8'h00, 8'hBE, 1'b0, 1'b1);
    @(negedge sys_clk);
    #1;
    check_out("stall_lo", 2'b00, 1'b1, 8'h00, 8'hEF, 1'b1, 1'b1);
    check("stall.status_low", 32'(status_low), 32'h3);

    // Reset pulse during SPLIT_LO discards the word.
    @(negedge sys_clk);
    drive(2'b11, 2'b01, 16'hCAFE, 16'h0000, 4'h1, 4'h0, 1'b1, 1'b1);
    #1;
    check("rst_seq.grant_lane0", 32'(in_ready), 32'h1);
    @(negedge sys_clk);
    drive(2'b11, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check_out("rst_seq.hi_beat", 2'b00, 1'b1, 8'h00, 8'hCA, 1'b0, 1'b0);
    @(negedge sys_clk);
    #1;
    check_out("rst_seq.lo_beat", 2'b00, 1'b1, 8'h00, 8'hFE, 1'b1, 1'b0);
    sys_reset_n = 1'b0;
    #1;
    check_out("rst_seq.async", 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("rst_seq.status_low",   32'(status_low),   32'h0);
    check("rst_seq.system_ready", 32'(system_ready), 32'h1);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;

    // Both lanes continuously valid: grants alternate 0,1,0,1 without bubbles.
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      drive(2'b11, 2'b11, 16'hC0C0, 16'hD1D1, 4'h0, 4'h0, 1'b0, 1'b1);
      #1;
      check($sformatf("rr%0d.in_ready", c), 32'(in_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d.out_valid", c), 32'(out_valid), (c > 0) ? 32'h1 : 32'h0);
      if (c > 0) begin
        check($sformatf("rr%0d.out_lane", c), 32'(out_lane), 32'((c - 1) % 2));
        check($sformatf("rr%0d.out_hi", c), 32'(out_hi), (c % 2 == 1) ? 32'hC0 : 32'hD1);
      end
    end
    @(negedge sys_clk);
    drive(2'b11, 2'b00, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check_out("rr_drain", 2'b00, 1'b1, 8'hD1, 8'hD1, 1'b1, 1'b1);
    @(negedge sys_clk);
    #1;
    check("rr_idle.system_ready", 32'(system_ready), 32'h1);
    check("rr_idle.out_valid",    32'(out_valid),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
